// File: rtl/myproject_mul_share_arb.sv
// rtl/myproject_mul_share_arb.sv - round-robin scheduler sharing one signed 12x6 multiplier
module myproject_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 12,
  parameter int B_W     = 6,
  parameter int P_W     = 18
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  // stage S1: operands and tag
  logic              s1_v;
  logic [A_W-1:0]    s1_a;
  logic [B_W-1:0]    s1_b;
  logic [ID_W-1:0]   s1_id;

  // stage S2: product and tag
  logic              s2_v;
  logic [P_W-1:0]    s2_p;
  logic [ID_W-1:0]   s2_id;

  // lane searched first on the next arbitration
  logic [ID_W-1:0]   rr_ptr;

  logic              adv1;
  logic              adv2;
  logic              found;
  logic              hs;
  logic [ID_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [A_W-1:0]    gnt_a;
  logic [B_W-1:0]    gnt_b;
  logic signed [P_W-1:0] a_ext;
  logic signed [P_W-1:0] b_ext;
  logic signed [P_W-1:0] prod;
  int                idx;

  // each stage may move when the one ahead of it is empty or moving
  assign adv2 = !s2_v || res_ready;
  assign adv1 = !s1_v || adv2;

  // round-robin search starting at rr_ptr, then mux the winner's operands
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    gnt_oh = '0;
    gnt_a  = '0;
    gnt_b  = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    if (found) gnt_oh[gnt_id] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_a = req_a[i*A_W +: A_W];
        gnt_b = req_b[i*B_W +: B_W];
      end
    end
  end

  // ready is withheld during reset so no requester sees a phantom accept
  assign hs        = found && adv1;
  assign req_ready = gnt_oh & {NUM_REQ{adv1 && !ap_rst}};

  // full-precision signed product; P_W = A_W + B_W so truncation never loses bits
  assign a_ext = {{(P_W-A_W){s1_a[A_W-1]}}, s1_a};
  assign b_ext = {{(P_W-B_W){s1_b[B_W-1]}}, s1_b};
  assign prod  = a_ext * b_ext;

  // control state: stage valid bits and round-robin pointer
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (adv2) s2_v <= s1_v;
      if (adv1) s1_v <= hs;
      if (hs) rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // data registers, qualified by the valid bits so they need no reset
  always_ff @(posedge ap_clk) begin
    if (hs) begin
      s1_a  <= gnt_a;
      s1_b  <= gnt_b;
      s1_id <= gnt_id;
    end
    if (adv2 && s1_v) begin
      s2_p  <= prod;
      s2_id <= s1_id;
    end
  end

  assign res_valid = s2_v;
  assign res_data  = s2_p;
  assign res_id    = s2_id;
  assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// tb/tb_myproject_mul_share_arb.sv - randomized scoreboard bench for the shared multiplier
module tb_myproject_mul_share_arb;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int BW = 6;
  localparam int PW = 18;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [PW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic            busy;

  int a_arr [N];
  int b_arr [N];
  int checks   = 0;
  int failures = 0;
  int sb_q  [$];
  int sb_id [$];
  int ptr = 0;
  logic [N-1:0] last_hs = '0;
  bit drv_en = 1'b0;
  int pv = 0;
  int pr = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_mul_share_arb #(.NUM_REQ(N), .ID_W(IW), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input int a, input int b, input bit v);
    a_arr[i] = a;
    b_arr[i] = b;
    req_a[i*AW +: AW] = AW'(a);
    req_b[i*BW +: BW] = BW'(b);
    req_valid[i] = v;
  endtask

  function automatic int rand_a();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  function automatic int rand_b();
    return int'($urandom_range(63)) - 32;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    tick();
    ap_rst = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int exp_d, input int exp_id);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!res_valid && n < 10) begin
      @(negedge ap_clk);
      n++;
    end
    chk({tag, "_valid"}, int'(res_valid), 1);
    chk({tag, "_data"}, int'($signed(res_data)), exp_d);
    chk({tag, "_id"}, int'(res_id), exp_id);
  endtask

  task automatic send(input int lane, input int a, input int b);
    int n;
    n = 0;
    tick();
    set_lane(lane, a, b, 1'b1);
    @(negedge ap_clk);
    while (!req_ready[lane] && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    chk("send_accept", int'(req_ready[lane]), 1);
    tick();
    set_lane(lane, a, b, 1'b0);
  endtask

  // reference model: round-robin grant rule, two-entry occupancy rule, FIFO of products
  always @(negedge ap_clk) begin
    int g;
    int l;
    bit acc;
    logic [N-1:0] exp_rdy;
    last_hs = '0;
    if (ap_rst) begin
      chk("rst_ready", int'(req_ready), 0);
      sb_q.delete();
      sb_id.delete();
      ptr = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        l = (ptr + k) % N;
        if (g < 0 && req_valid[l]) g = l;
      end
      acc = (sb_q.size() < 2) || res_ready;
      exp_rdy = '0;
      if (g >= 0 && acc) exp_rdy[g] = 1'b1;
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          chk("res_unexpected", int'(res_valid), 0);
        end else begin
          chk("res_data", int'($signed(res_data)), sb_q.pop_front());
          chk("res_id", int'(res_id), sb_id.pop_front());
        end
      end
      last_hs = req_valid & req_ready;
      if (g >= 0 && req_ready[g]) begin
        sb_q.push_back(a_arr[g] * b_arr[g]);
        sb_id.push_back(g);
        ptr = (g + 1) % N;
      end
    end
  end

  // random requesters: a lane only takes new operands once idle or just accepted
  always @(posedge ap_clk) begin
    #1;
    if (drv_en) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_hs[i])
          set_lane(i, rand_a(), rand_b(), $urandom_range(99) < pv);
      end
      res_ready = ($urandom_range(99) < pr);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) set_lane(i, 0, 0, 1'b0);
    res_ready = 1'b1;
    do_reset();

    // T1: single operation latency and value
    set_lane(0, 2047, 31, 1'b1);
    @(negedge ap_clk);
    chk("t1_ready", int'(req_ready), 1);
    tick();
    set_lane(0, 2047, 31, 1'b0);
    @(negedge ap_clk);
    chk("t1_lat_valid", int'(res_valid), 0);
    chk("t1_busy", int'(busy), 1);
    tick();
    @(negedge ap_clk);
    chk("t1_valid", int'(res_valid), 1);
    chk("t1_data", int'($signed(res_data)), 63457);
    chk("t1_id", int'(res_id), 0);
    tick();
    @(negedge ap_clk);
    chk("t1_idle", int'(busy), 0);

    // T2: sign extremes
    send(1, -2048, -32);
    wait_res("t2a", 65536, 1);
    send(1, -2048, 31);
    wait_res("t2b", -63488, 1);
    chk("t2b_hex", int'(res_data), 32'h30800);

    // T3: all lanes continuously valid
    do_reset();
    pv = 100;
    pr = 100;
    drv_en = 1'b1;
    n = 0;
    @(negedge ap_clk);
    while (!res_valid && n < 10) begin
      @(negedge ap_clk);
      n++;
    end
    for (int k = 0; k < 12; k++) begin
      chk("t3_valid", int'(res_valid), 1);
      chk("t3_id", int'(res_id), k % N);
      @(negedge ap_clk);
    end

    // T4: five-cycle output stall
    pr = 0;
    tick();
    @(negedge ap_clk);
    for (int k = 2; k <= 5; k++) begin
      @(negedge ap_clk);
      chk("t4_ready", int'(req_ready), 0);
      chk("t4_valid", int'(res_valid), 1);
      chk("t4_busy", int'(busy), 1);
      if (sb_q.size() > 0) begin
        chk("t4_data", int'($signed(res_data)), sb_q[0]);
        chk("t4_id", int'(res_id), sb_id[0]);
      end
    end
    pr = 100;
    repeat (8) tick();

    // random traffic with random backpressure
    pv = 60;
    pr = 50;
    repeat (400) tick();
    pv = 0;
    pr = 100;
    repeat (12) tick();
    @(negedge ap_clk);
    chk("drain_busy", int'(busy), 0);
    chk("drain_left", sb_q.size(), 0);
    drv_en = 1'b0;

    // T5: pointer wraps after lane 3
    tick();
    for (int i = 0; i < N; i++) set_lane(i, 0, 0, 1'b0);
    res_ready = 1'b1;
    do_reset();
    set_lane(3, 100, -3, 1'b1);
    @(negedge ap_clk);
    chk("t5_l3", int'(req_ready), 8);
    tick();
    set_lane(3, 100, -3, 1'b0);
    set_lane(2, -7, 9, 1'b1);
    @(negedge ap_clk);
    chk("t5_l2", int'(req_ready), 4);
    tick();
    set_lane(2, -7, 9, 1'b0);
    wait_res("t5a", -300, 3);
    wait_res("t5b", -63, 2);

    // T6: asynchronous reset mid-stream
    pv = 100;
    pr = 100;
    drv_en = 1'b1;
    repeat (7) tick();
    drv_en = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("t6_valid", int'(res_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready", int'(req_ready), 0);
    for (int i = 0; i < N; i++) set_lane(i, 0, 0, 1'b0);
    set_lane(1, 5, 6, 1'b1);
    set_lane(3, 7, 8, 1'b1);
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t6_first", int'(req_ready), 2);
    tick();
    set_lane(1, 5, 6, 1'b0);
    wait_res("t6r", 30, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
